// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum engine: folds a valid/ready frame of words and holds the result for a consumer.
// Optional macro XOR_CHECK_EN adds chk_err/err_count for frames that carry their own checksum word.
module xor_checksum_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
`ifdef XOR_CHECK_EN
  ,
  output logic             chk_err,
  output logic [7:0]       err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_parity_q, out_parity_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d   = in_data;
          count_d = CW'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_d = acc_q ^ in_data;
          // Count saturates; the sticky overflow flag records the excess words.
          if (count_q == MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_xfer) begin
          state_d      = IDLE;
          acc_d        = '0;
          count_d      = '0;
          ovf_d        = 1'b0;
          out_valid_d  = 1'b0;
          out_sum_d    = '0;
          out_parity_d = 1'b0;
          out_count_d  = '0;
          out_ovf_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Result registers load on the edge that accepts the last word.
    if (in_xfer && in_last) begin
      out_valid_d  = 1'b1;
      out_sum_d    = acc_d;
      out_parity_d = ^acc_d;
      out_count_d  = count_d;
      out_ovf_d    = ovf_d;
    end

    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_parity   = out_parity_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

`ifdef XOR_CHECK_EN
  logic       chk_err_q, chk_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    chk_err_d = chk_err_q;
    err_cnt_d = err_cnt_q;
    if (in_xfer && in_last) begin
      chk_err_d = (acc_d != '0);
    end else if (out_xfer) begin
      chk_err_d = 1'b0;
    end
    if (out_xfer && chk_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      chk_err_q <= chk_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign chk_err   = chk_err_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Bench for xor_checksum_unit (WIDTH=8, MAX_WORDS=4): directed frames plus random frames against a queue-based model.
module tb_xor_checksum_unit;

  localparam int MAXW = 4;
  localparam int CWT  = $clog2(MAXW + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_sum;
  logic            out_parity;
  logic [CWT-1:0]  out_count;
  logic            out_overflow;
`ifdef XOR_CHECK_EN
  logic            chk_err;
  logic [7:0]      err_count;
`endif

  int         checks   = 0;
  int         failures = 0;
  int         err_exp  = 0;
  logic [7:0] frame_q[$];

  xor_checksum_unit #(.WIDTH(8), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_parity   (out_parity),
    .out_count    (out_count),
    .out_overflow (out_overflow)
`ifdef XOR_CHECK_EN
    ,
    .chk_err      (chk_err),
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_sum"},   32'(out_sum), 0);
    chk({tag, "_parity"},    32'(out_parity), 0);
    chk({tag, "_count"},     32'(out_count), 0);
    chk({tag, "_overflow"},  32'(out_overflow), 0);
`ifdef XOR_CHECK_EN
    chk({tag, "_chk_err"},   32'(chk_err), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
`endif
  endtask

  task automatic chk_result(input logic [7:0] s, input int cnt, input logic ovf);
    chk("out_valid", 32'(out_valid), 1);
    chk("out_sum", 32'(out_sum), 32'(s));
    chk("out_parity", 32'(out_parity), 32'($countones(s) % 2));
    chk("out_count", 32'(out_count), 32'(cnt));
    chk("out_overflow", 32'(out_overflow), 32'(ovf));
    chk("in_ready_hold", 32'(in_ready), 0);
`ifdef XOR_CHECK_EN
    chk("chk_err", 32'(chk_err), 32'(s != 8'h00));
`endif
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_accept", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Sends frame_q (gap<0: random idle gaps), holds the result for 'hold' cycles, then consumes it.
  task automatic run_frame(input int gap, input int hold);
    logic [7:0] s;
    int         n, cnt, g;
    logic       ovf;
    s = 8'h00;
    n = frame_q.size();
    foreach (frame_q[i]) s = s ^ frame_q[i];
    cnt = (n > MAXW) ? MAXW : n;
    ovf = (n > MAXW);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          in_last  = 1'($urandom);
          @(negedge clk);
        end
      end
      send_word(frame_q[i], (i == n - 1));
    end
    chk_result(s, cnt, ovf);
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk_result(s, cnt, ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (s != 8'h00 && err_exp < 255) err_exp++;
    chk("out_valid_drop", 32'(out_valid), 0);
    chk("in_ready_resume", 32'(in_ready), 1);
`ifdef XOR_CHECK_EN
    chk("chk_err_idle", 32'(chk_err), 0);
    chk("err_count", 32'(err_count), 32'(err_exp));
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 1);

    // Reset mid-frame discards the partial frame
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_midframe");
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
    @(negedge clk);
    chk("in_ready_after_rst2", 32'(in_ready), 1);
    frame_q = {8'h05};
    run_frame(0, 0);

    frame_q = {8'h0F, 8'hF0, 8'h33};
    run_frame(0, 0);
    frame_q = {8'h0F, 8'hF0, 8'h33};
    run_frame(0, 5);
    frame_q = {8'hAA};
    run_frame(0, 0);
    frame_q = {8'h01, 8'h02};
    run_frame(3, 1);
    frame_q = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_frame(0, 0);
    frame_q = {8'h80};
    run_frame(0, 0);
    frame_q = {8'h01, 8'h02, 8'h04, 8'h08};
    run_frame(0, 0);
    frame_q = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    run_frame(0, 0);

    // Reset while holding a result
    send_word(8'h77, 1'b1);
    chk("hold_before_rst", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
    @(negedge clk);
    chk("in_ready_after_rst3", 32'(in_ready), 1);

`ifdef XOR_CHECK_EN
    frame_q = {8'h12, 8'h34, 8'h26};
    run_frame(0, 0);
    frame_q = {8'h12, 8'h34};
    run_frame(0, 0);
    frame_q = {8'h01};
    repeat (256) run_frame(0, 0);
    chk("err_count_saturated", 32'(err_count), 255);
`endif

    repeat (40) begin
      int len;
      len = int'($urandom_range(1, 7));
      frame_q = {};
      repeat (len) frame_q.push_back(8'($urandom));
      run_frame(-1, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
